imem_loader: RTL and testbench

- Produces RV32I instruction words for the six opcode classes the main decoder consumes: lw, sw, R-type, beq, I-type ALU and jal.
- Accepts instruction fields one per valid/ready handshake and encodes them into 32-bit machine words.
- Writes each word sequentially into instruction memory through a one-stage registered write port.
- Used by the bench and bring-up flow to load programs before the core is released from reset.

---
 rtl/imem_loader.sv | 92 +++++++++
 tb/tb_imem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: encodes RV32I fields (lw/sw/R/beq/I-ALU/jal) per
// handshake and writes them sequentially through a one-stage registered port.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  parameter int          CW        = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    kind,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    funct3,
  input  logic          funct7b5,
  input  logic [20:0]   imm,
  input  logic          last,
  output logic          we,
  output logic [31:0]   waddr,
  output logic [31:0]   wdata,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept, bad, restart;
  logic [31:0] enc;
  logic [CW:0] words;

  // Words already committed plus the one sitting in the write register.
  assign words    = {1'b0, count} + (CW+1)'(we);
  assign in_ready = (state == LOAD) && (words < (CW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign bad      = (kind > 3'd5) || (((kind == 3'd3) || (kind == 3'd5)) && imm[0]);
  assign restart  = start && ((state == IDLE) || (state == DONE));
  assign waddr    = BASE_ADDR + (32'(count) << 2);
  assign done     = (state == DONE);

  always_comb begin
    enc = '0;
    case (kind)
      3'd0: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd1: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd2: enc = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
      3'd3: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      3'd4: begin
        enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
        if (funct3 == 3'b101 && funct7b5) enc[31:25] = 7'b0100000;  // srai
      end
      3'd5: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      default: enc = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (accept && last) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      we    <= 1'b0;
      wdata <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= accept && !bad;
      if (accept && !bad) wdata <= enc;
      if (restart) begin
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (we && count != CW'(DEPTH)) count <= count + CW'(1);
        if (accept && bad) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized + directed bench for imem_loader against a cycle-level behavioural model.
module tb_imem_loader;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 0, reset = 0, start = 0, in_valid = 0, last = 0, funct7b5 = 0;
  logic [2:0]  kind = 0, funct3 = 0;
  logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
  logic [20:0] imm = 0;
  logic        in_ready, we, done, err;
  logic [31:0] waddr, wdata;
  logic [2:0]  count;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5),
    .imm(imm), .last(last), .we(we), .waddr(waddr), .wdata(wdata), .count(count),
    .done(done), .err(err));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Reference model: session flags, committed word count, pending write.
  bit          m_load, m_drain, m_done, m_err, pend_we;
  int          m_count;
  logic [31:0] pend_addr, pend_data;

  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_enc(input int k, input logic [31:0] d, s1, s2, f3,
                                          input logic [31:0] f7, input logic [31:0] im);
    logic [31:0] top;
    case (k)
      0: return (fld(im,11,0) << 20) | (s1 << 15) | (32'd2 << 12) | (d << 7) | 32'd3;
      1: return (fld(im,11,5) << 25) | (s2 << 20) | (s1 << 15) | (32'd2 << 12)
              | (fld(im,4,0) << 7) | 32'd35;
      2: return (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'd51;
      3: return (fld(im,12,12) << 31) | (fld(im,10,5) << 25) | (s2 << 20) | (s1 << 15)
              | (fld(im,4,1) << 8) | (fld(im,11,11) << 7) | 32'd99;
      4: begin
        top = (f3 == 5 && f7 == 1) ? (32'd1024 + fld(im,4,0)) : fld(im,11,0);
        return (top << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 32'd19;
      end
      5: return (fld(im,20,20) << 31) | (fld(im,10,1) << 21) | (fld(im,11,11) << 20)
              | (fld(im,19,12) << 12) | (d << 7) | 32'd111;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_ready();
    return m_load && !m_drain && (m_count + int'(pend_we)) < DEPTH;
  endfunction

  task automatic m_clear();
    m_load = 0; m_drain = 0; m_done = 0; m_err = 0; pend_we = 0; m_count = 0;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit v, input bit st);
    bit acc, bd, n_pend;
    int nc;
    chk("we", we, pend_we);
    if (pend_we) begin
      chk("waddr", waddr, pend_addr);
      chk("wdata", wdata, pend_data);
    end
    chk("count", count, m_count);
    chk("done", done, m_done);
    chk("err", err, m_err);
    in_valid = v; start = st;
    #1 chk("in_ready", in_ready, m_ready());
    acc = v && m_ready();
    bd  = kind > 5 || ((kind == 3 || kind == 5) && imm[0]);
    nc  = m_count + int'(pend_we);
    n_pend = 0;
    if (st && !m_load && !m_drain) begin
      m_load = 1; m_done = 0; m_err = 0; nc = 0;
    end else if (m_drain) begin
      m_drain = 0; m_done = 1;
    end else if (acc) begin
      if (bd) m_err = 1;
      else begin
        n_pend = 1;
        pend_addr = BASE + 32'(4 * nc);
        pend_data = ref_enc(int'(kind), 32'(rd), 32'(rs1), 32'(rs2), 32'(funct3),
                            32'(funct7b5), 32'(imm));
      end
      if (last) begin m_load = 0; m_drain = 1; end
    end
    pend_we = n_pend; m_count = nc;
    @(negedge clk);
    in_valid = 0; start = 0;
  endtask

  task automatic beat(input int k, input int d, input int s1, input int s2, input int f3,
                      input bit f7, input int im, input bit lst);
    kind = 3'(k); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); funct3 = 3'(f3);
    funct7b5 = f7; imm = 21'(im); last = lst;
    step(1, 0);
  endtask

  task automatic set_rand();
    int r;
    r = $urandom_range(0, 9);
    kind = (r > 7) ? 3'd0 : 3'(r);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7b5 = 1'($urandom); imm = 21'($urandom);
    last = ($urandom_range(0, 4) == 0);
  endtask

  task automatic pulse_reset();
    reset = 0; m_clear();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  initial begin
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0); chk("rst_we", we, 0); chk("rst_waddr", waddr, BASE);
    chk("rst_wdata", wdata, 0); chk("rst_count", count, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1;
    @(negedge clk);

    // start with a simultaneous valid beat: start wins, beat not taken
    kind = 0; last = 1;
    step(1, 1);
    beat(0, 5, 2, 0, 0, 0, 8, 1);
    chk("lw_word", wdata, 32'h00812283);
    chk("lw_addr", waddr, 32'h0);
    step(0, 0); step(0, 0);

    // add, sw, beq, jal back to back
    step(0, 1);
    beat(2, 3, 1, 2, 0, 0, 0, 0);
    chk("add_word", wdata, 32'h002081B3);
    beat(1, 0, 3, 6, 0, 0, 4, 0);
    chk("sw_word", wdata, 32'h0061A223);
    chk("sw_addr", waddr, 32'h4);
    beat(3, 0, 1, 2, 0, 0, -4, 0);
    chk("beq_word", wdata, 32'hFE208EE3);
    beat(5, 1, 0, 0, 0, 0, 8, 1);
    chk("jal_word", wdata, 32'h008000EF);
    step(1, 1);  // start in DRAIN is ignored
    chk("done_hi", done, 1);
    chk("done_rdy", in_ready, 0);
    step(0, 0);

    // errors: illegal kind, odd branch offset, then a good lw
    step(0, 1);
    beat(6, 1, 1, 1, 0, 0, 0, 0);
    beat(3, 0, 1, 2, 0, 0, 3, 0);
    chk("err_sticky", err, 1);
    beat(0, 7, 4, 0, 0, 0, 12, 1);
    chk("err_lw_addr", waddr, 32'h0);
    step(0, 0); step(0, 0);

    // overfill: six beats without last against DEPTH=4
    step(0, 1);
    for (int i = 0; i < 6; i++) beat(4, i, 1, 0, 5, 1, i + 33, 0);
    step(0, 0); step(0, 0);
    chk("full_count", count, 3'd4);
    chk("full_done", done, 0);

    // reset while a write is pending
    pulse_reset();
    step(0, 1);
    beat(0, 2, 3, 0, 0, 0, 16, 0);
    reset = 0;
    #1 chk("rst_mid_we", we, 0);
    chk("rst_mid_count", count, 0);
    m_clear();
    @(negedge clk);
    reset = 1;
    step(0, 1);
    beat(0, 2, 3, 0, 0, 0, 16, 1);
    chk("restart_addr", waddr, BASE);
    step(0, 0); step(0, 0);

    // randomized sessions
    for (int s = 0; s < 60; s++) begin
      set_rand();
      step(1'($urandom), 1);
      for (int c = 0; c < 9 && (m_load || m_drain); c++) begin
        set_rand();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
      if (m_load) pulse_reset();
      else begin step(0, 0); step(0, 0); end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
